// File: rtl/frame_pixel_sequencer.sv
// frame_pixel_sequencer
//
// Feeds the pixel write stage from a raster-ordered pixel stream. Pixels are
// taken over a valid/ready handshake, the column/row position inside an
// IMG_W x IMG_H frame is tracked, and each pixel is presented with its linear
// frame-buffer address together with a one-cycle writepixel strobe. The write
// stage acts on the rising edge of writepixel, so strobes are always separated
// by at least one low cycle. One start request captures exactly one frame.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : asynchronous, active-high reset
//   start      : begin capturing one frame (honoured in IDLE only)
//   abort      : abandon the current frame (honoured in RUN/STROBE only)
//   in_valid   : upstream pixel valid
//   in_pixel   : upstream pixel data
//   in_ready   : a pixel can be accepted this cycle
//   writepixel : one-cycle write strobe to the write stage
//   wr_addr    : linear address, row*IMG_W + col
//   wr_data    : pixel to write
//   busy       : high while capturing (RUN or STROBE)
//   frame_done : one-cycle pulse after the last pixel's strobe
module frame_pixel_sequencer #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [PIX_W-1:0]  in_pixel,
   output logic              in_ready,
   output logic              writepixel,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              frame_done
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STROBE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]    wr_data_q, wr_data_d;
   logic                in_ready_q, writepixel_q, busy_q, frame_done_q;

   // Next-state logic. During STROBE the counters still describe the pixel
   // being strobed, so the last-pixel test looks at them before they advance.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end

         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (in_valid) begin
               wr_addr_d = addr_q;
               wr_data_d = in_pixel;
               state_d   = S_STROBE;
            end
         end

         S_STROBE: begin
            addr_d = addr_q + ADDR_ONE;
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + ROW_ONE;
            end else begin
               col_d = col_q + COL_ONE;
            end

            // Abort still lets this cycle's strobe finish but skips DONE.
            if (abort) begin
               state_d = S_IDLE;
            end else if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state and registered, so they
   // line up exactly with the state they describe and are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         addr_q       <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         in_ready_q   <= 1'b0;
         writepixel_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         in_ready_q   <= (state_d == S_RUN);
         writepixel_q <= (state_d == S_STROBE);
         busy_q       <= (state_d == S_RUN) || (state_d == S_STROBE);
         frame_done_q <= (state_d == S_DONE);
      end
   end

   assign in_ready   = in_ready_q;
   assign writepixel = writepixel_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_pixel_sequencer.sv
// Bench for frame_pixel_sequencer on a 4x3 frame. A behavioural model tracks
// what the sequencer must present after every clock edge from the frame rules
// (pixels accepted so far, whether a strobe or completion is due), and a
// per-cycle compare process checks every output against it. Literal checks on
// the logged strobe sequence pin the model to hand-computed values.
module tb_frame_pixel_sequencer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int PW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_pixel = '0;
   logic          in_ready;
   logic          writepixel;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_data;
   logic          busy;
   logic          frame_done;

   frame_pixel_sequencer #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (PW),
      .ADDR_W(AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_pixel  (in_pixel),
      .in_ready  (in_ready),
      .writepixel(writepixel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Behavioural model: expected outputs for the cycle following each edge.
   logic          m_ready = 1'b0;
   logic          m_wp    = 1'b0;
   logic          m_done  = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [PW-1:0] m_data  = '0;
   int            m_n     = 0;   // pixels accepted in the current frame

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready <= 1'b0;
         m_wp    <= 1'b0;
         m_done  <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
         m_n     <= 0;
      end else begin
         m_ready <= 1'b0;
         m_wp    <= 1'b0;
         m_done  <= 1'b0;
         if (m_wp) begin
            // a strobe cycle ends: frame complete, next pixel, or abandoned
            if (!abort) begin
               if (m_n == W * H) m_done  <= 1'b1;
               else              m_ready <= 1'b1;
            end
         end else if (m_ready) begin
            if (!abort) begin
               if (in_valid) begin
                  m_addr <= AW'((m_n / W) * W + (m_n % W));
                  m_data <= in_pixel;
                  m_n    <= m_n + 1;
                  m_wp   <= 1'b1;
               end else begin
                  m_ready <= 1'b1;
               end
            end
         end else if (!m_done && start) begin
            m_ready <= 1'b1;
            m_n     <= 0;
         end
      end
   end

   // Per-cycle compare plus a log of every strobe for sequence checks.
   int   cyc = 0;
   int   s_addr[$];
   int   s_data[$];
   int   s_cyc[$];
   int   done_cnt = 0;
   int   done_cyc = -1;
   logic prev_wp  = 1'b0;

   always @(negedge clk) begin
      chk("outputs", 32'({in_ready, writepixel, busy, frame_done, wr_addr, wr_data}),
          32'({m_ready, m_wp, (m_ready | m_wp), m_done, m_addr, m_data}));
      if (writepixel) begin
         chk("no_back_to_back_strobe", 32'(prev_wp), 32'(0));
         s_addr.push_back(int'(wr_addr));
         s_data.push_back(int'(wr_data));
         s_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      prev_wp <= writepixel;
      cyc     <= cyc + 1;
   end

   // Runs one frame from IDLE. duty: in_valid percentage (100 = held high with
   // pixels 0x10+k). noise: pulse start randomly while busy and during DONE.
   // abort_k / rst_k: abort or reset once k pixels have been accepted (-1 = off).
   task automatic do_frame(input int duty, input bit noise, input int abort_k,
                           input int rst_k, output bit finished);
      int k;
      k = 0;
      finished = 1'b0;
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (frame_done) begin
            finished = 1'b1;
            in_valid = 1'b0;
            start = noise;
            @(negedge clk);
            break;
         end
         if (k == abort_k) begin
            in_valid = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            break;
         end
         if (k == rst_k) begin
            in_valid = 1'b0;
            #2 rst = 1'b1;
            #1 chk("async_reset_outputs",
                   32'({in_ready, writepixel, busy, frame_done, wr_addr, wr_data}), 32'(0));
            @(negedge clk);
            rst = 1'b0;
            break;
         end
         in_valid = ($urandom_range(0, 99) < duty);
         in_pixel = (duty >= 100) ? PW'(16 + k) : PW'($urandom);
         start = noise && ($urandom_range(0, 7) == 0);
         if (in_valid && in_ready) k++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      bit fin;
      int b, bd, bad;

      // Reset held with active inputs: everything stays at reset values.
      rst = 1'b1;
      in_valid = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          32'({in_ready, writepixel, busy, frame_done, wr_addr, wr_data}), 32'(0));
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle_not_ready", 32'(in_ready), 32'(0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ready_after_start", 32'(in_ready), 32'(1));
      abort = 1'b1;           // abort while waiting in RUN
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_run_idle", 32'({in_ready, busy}), 32'(0));
      repeat (2) @(negedge clk);

      // Full frame at maximum rate.
      b = s_addr.size();
      bd = done_cnt;
      do_frame(100, 1'b0, -1, -1, fin);
      chk("full_finished", 32'(fin), 32'(1));
      chk("full_strobe_count", 32'(s_addr.size() - b), 32'(12));
      if (s_addr.size() - b == 12) begin
         bad = 0;
         for (int i = 0; i < 12; i++) begin
            chk("full_addr", 32'(s_addr[b + i]), 32'(i));
            chk("full_data", 32'(s_data[b + i]), 32'(16 + i));
            if (i > 0 && s_cyc[b + i] - s_cyc[b + i - 1] != 2) bad++;
         end
         chk("full_strobe_spacing", 32'(bad), 32'(0));
         chk("row_wrap_addr", 32'(s_addr[b + 4]), 32'(4));
         chk("done_latency", 32'(done_cyc - s_cyc[b + 11]), 32'(1));
      end
      chk("full_done_count", 32'(done_cnt - bd), 32'(1));
      chk("full_idle_after", 32'({in_ready, busy}), 32'(0));

      // Bubbly input with stray start pulses during RUN/STROBE/DONE.
      for (int f = 0; f < 3; f++) begin
         b = s_addr.size();
         bd = done_cnt;
         do_frame(30, 1'b1, -1, -1, fin);
         chk("bubbly_finished", 32'(fin), 32'(1));
         chk("bubbly_strobe_count", 32'(s_addr.size() - b), 32'(12));
         if (s_addr.size() - b == 12)
            for (int i = 0; i < 12; i++) chk("bubbly_addr", 32'(s_addr[b + i]), 32'(i));
         chk("bubbly_done_count", 32'(done_cnt - bd), 32'(1));
      end

      // Abort after 5 pixels: the strobe for address 4 completes, no done.
      b = s_addr.size();
      bd = done_cnt;
      do_frame(100, 1'b0, 5, -1, fin);
      chk("abort_strobe_count", 32'(s_addr.size() - b), 32'(5));
      if (s_addr.size() - b == 5) chk("abort_last_addr", 32'(s_addr[b + 4]), 32'(4));
      chk("abort_no_done", 32'(done_cnt - bd), 32'(0));
      chk("abort_idle", 32'({in_ready, busy}), 32'(0));

      // Restart after abort begins at address 0.
      b = s_addr.size();
      do_frame(70, 1'b0, -1, -1, fin);
      chk("restart_finished", 32'(fin), 32'(1));
      if (s_addr.size() > b) chk("restart_first_addr", 32'(s_addr[b]), 32'(0));

      // Asynchronous reset mid-frame, then a fresh frame from address 0.
      bd = done_cnt;
      do_frame(100, 1'b0, -1, 7, fin);
      chk("reset_no_done", 32'(done_cnt - bd), 32'(0));
      b = s_addr.size();
      do_frame(50, 1'b1, -1, -1, fin);
      chk("post_reset_finished", 32'(fin), 32'(1));
      chk("post_reset_count", 32'(s_addr.size() - b), 32'(12));
      if (s_addr.size() > b) chk("post_reset_first_addr", 32'(s_addr[b]), 32'(0));

      // Random mix of duty cycles and aborts, checked by the model every cycle.
      for (int f = 0; f < 6; f++) begin
         do_frame(int'($urandom_range(20, 100)), 1'b1,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1, -1, fin);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
